// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the write-back stage: sequencer encodings,
// frame lengths, suppressed opcodes and the captured-instruction record.
package wb_regfile_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WAIT_1  = 4'd1,
        WAIT_2  = 4'd2,
        WAIT_3  = 4'd3,
        WAIT_4  = 4'd4,
        WAIT_5  = 4'd5,
        WAIT_6  = 4'd6,
        WAIT_7  = 4'd7,
        WAIT_8  = 4'd8,
        WAIT_9  = 4'd9,
        WAIT_10 = 4'd10,
        CAPTURE = 4'd11,
        COMMIT  = 4'd12
    } state_t;

    localparam int FRAME_LEN       = 12;
    localparam int FIRST_FRAME_LEN = 13;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_ST  = 5'h11;
    localparam logic [4:0] OP_JMP = 5'h12;
    localparam logic [4:0] OP_BEQ = 5'h13;
    localparam logic [4:0] OP_BNE = 5'h14;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  opcd;
        logic [4:0]  addr;
        logic        opt;
    } wb_req_t;

    // Stores and control-flow ops carry no register result.
    function automatic logic is_suppressed(input logic [4:0] op);
        return (op == OP_NOP) || (op == OP_ST) || (op == OP_JMP) ||
               (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/wb_regfile_reg_file_32x16.sv
// 32x16 register storage with low-byte write merge and read ports that
// forward the value being written in the same cycle.
module reg_file_32x16 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [15:0] wdata,
    input  logic        byte_wr,
    input  logic [4:0]  ra_addr,
    input  logic [4:0]  rb_addr,
    output logic [15:0] ra_data,
    output logic [15:0] rb_data,
    output logic [15:0] wr_value
);

    logic [15:0] mem [32];

    // Full resulting register value; also what gets forwarded downstream.
    assign wr_value = byte_wr ? {mem[waddr][15:8], wdata[7:0]} : wdata;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wr_value;
        end
    end

    always_comb begin
        ra_data = mem[ra_addr];
        if (we && ra_addr == waddr) ra_data = wr_value;
        if (ra_addr == 5'd0)        ra_data = '0;
    end

    always_comb begin
        rb_data = mem[rb_addr];
        if (we && rb_addr == waddr) rb_data = wr_value;
        if (rb_addr == 5'd0)        rb_data = '0;
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: fixed-length frame sequencer, capture of the delivered
// instruction, write-enable decode and forwarding copy of the last write.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA_IN,
    input  logic [4:0]  OPCD_IN,
    input  logic [4:0]  ADDR_REG_IN,
    input  logic        OPT_BIT_IN,
    input  logic        VALID_IN,
    input  logic [4:0]  RA_ADDR,
    input  logic [4:0]  RB_ADDR,
    output logic [15:0] RA_DATA,
    output logic [15:0] RB_DATA,
    output logic        WB_DONE,
    output logic [4:0]  WB_ADDR,
    output logic [15:0] WB_DATA
);

    state_t      state, state_nxt;
    logic        cap_en, com_en;
    wb_req_t     cap;
    logic        pending;
    logic        we;
    logic [15:0] wr_value;

    always_ff @(posedge CLK) begin
        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        if (RST) begin
            case (state)
                IDLE:    state_nxt = WAIT_1;
                WAIT_1, WAIT_2, WAIT_3, WAIT_4, WAIT_5,
                WAIT_6, WAIT_7, WAIT_8, WAIT_9:
                         state_nxt = state_t'(state + 4'd1);
                WAIT_10: state_nxt = CAPTURE;
                CAPTURE: state_nxt = COMMIT;
                COMMIT:  state_nxt = WAIT_1;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cap_en = (state == CAPTURE);
        com_en = (state == COMMIT);
    end

    // An invalid capture drops the pending write but keeps the old fields.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cap     <= '0;
            pending <= 1'b0;
        end else if (cap_en) begin
            if (VALID_IN) begin
                cap     <= '{data: DATA_IN, opcd: OPCD_IN, addr: ADDR_REG_IN, opt: OPT_BIT_IN};
                pending <= 1'b1;
            end else begin
                pending <= 1'b0;
            end
        end
    end

    assign we = RST && com_en && pending && !is_suppressed(cap.opcd) && (cap.addr != 5'd0);

    reg_file_32x16 u_rf (
        .CLK      (CLK),
        .RST      (RST),
        .we       (we),
        .waddr    (cap.addr),
        .wdata    (cap.data),
        .byte_wr  (cap.opt),
        .ra_addr  (RA_ADDR),
        .rb_addr  (RB_ADDR),
        .ra_data  (RA_DATA),
        .rb_data  (RB_DATA),
        .wr_value (wr_value)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            WB_DONE <= 1'b0;
            WB_ADDR <= '0;
            WB_DATA <= '0;
        end else begin
            WB_DONE <= we;
            if (we) begin
                WB_ADDR <= cap.addr;
                WB_DATA <= wr_value;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: frame timing, byte writes, suppression,
// invalid capture, commit-cycle bypass and mid-frame reset.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] DATA_IN = '0;
    logic [4:0]  OPCD_IN = '0;
    logic [4:0]  ADDR_REG_IN = '0;
    logic        OPT_BIT_IN = 1'b0;
    logic        VALID_IN = 1'b0;
    logic [4:0]  RA_ADDR = '0;
    logic [4:0]  RB_ADDR = '0;
    logic [15:0] RA_DATA, RB_DATA, WB_DATA;
    logic        WB_DONE;
    logic [4:0]  WB_ADDR;

    int n_chk = 0;
    int n_fail = 0;

    wb_regfile dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .OPCD_IN(OPCD_IN),
        .ADDR_REG_IN(ADDR_REG_IN), .OPT_BIT_IN(OPT_BIT_IN), .VALID_IN(VALID_IN),
        .RA_ADDR(RA_ADDR), .RB_ADDR(RB_ADDR), .RA_DATA(RA_DATA), .RB_DATA(RB_DATA),
        .WB_DONE(WB_DONE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] a,
                         input logic opt, input logic [15:0] d);
        VALID_IN = v; OPCD_IN = op; ADDR_REG_IN = a; OPT_BIT_IN = opt; DATA_IN = d;
    endtask

    // Runs n cycles; records WB_DONE pulses and RA_DATA in the last two-but-one cycles.
    task automatic run(input int n, output int dones, output int first,
                       output logic [15:0] ra_pre, output logic [15:0] ra_com);
        dones = 0; first = 0; ra_pre = '0; ra_com = '0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (WB_DONE) begin
                dones++;
                if (first == 0) first = i;
            end
            if (i == n - 2) ra_pre = RA_DATA;
            if (i == n - 1) ra_com = RA_DATA;
        end
    endtask

    int dn, fst;
    logic [15:0] rp, rc;
    logic [4:0] sup_ops [5];

    initial begin
        sup_ops = '{OP_NOP, OP_ST, OP_JMP, OP_BEQ, OP_BNE};

        // Reset
        RST = 1'b0;
        step(); step();
        check("rst_done", WB_DONE, 0);
        check("rst_addr", WB_ADDR, 0);
        check("rst_data", WB_DATA, 0);

        // First frame: 13 cycles to the write
        drive(1, 5'h01, 5'd5, 0, 16'hBEEF);
        RA_ADDR = 5'd5;
        RST = 1'b1;
        run(FIRST_FRAME_LEN, dn, fst, rp, rc);
        check("first_dones", dn, 1);
        check("first_cycle", fst, 13);
        check("first_wbaddr", WB_ADDR, 5);
        check("first_wbdata", WB_DATA, 16'hBEEF);
        check("first_r5", RA_DATA, 16'hBEEF);

        // Full write then low-byte merge on R7
        drive(1, 5'h01, 5'd7, 0, 16'h1234);
        RA_ADDR = 5'd7;
        run(FRAME_LEN, dn, fst, rp, rc);
        check("r7_full_dones", dn, 1);
        check("r7_full_cycle", fst, 12);
        check("r7_full", RA_DATA, 16'h1234);
        drive(1, 5'h01, 5'd7, 1, 16'h00AB);
        run(FRAME_LEN, dn, fst, rp, rc);
        check("r7_byte_dones", dn, 1);
        check("r7_byte_bypass", rc, 16'h12AB);
        check("r7_byte_wbdata", WB_DATA, 16'h12AB);
        check("r7_byte", RA_DATA, 16'h12AB);

        // Suppressed opcodes leave R3 alone
        drive(1, 5'h01, 5'd3, 0, 16'h3333);
        RA_ADDR = 5'd3;
        run(FRAME_LEN, dn, fst, rp, rc);
        check("r3_init", RA_DATA, 16'h3333);
        for (int k = 0; k < 5; k++) begin
            drive(1, sup_ops[k], 5'd3, 0, 16'hFFFF);
            run(FRAME_LEN, dn, fst, rp, rc);
            check($sformatf("sup_%0h_dones", sup_ops[k]), dn, 0);
            check($sformatf("sup_%0h_r3", sup_ops[k]), RA_DATA, 16'h3333);
        end

        // Register 0 write is dropped
        drive(1, 5'h01, 5'd0, 0, 16'hFFFF);
        RB_ADDR = 5'd0;
        run(FRAME_LEN, dn, fst, rp, rc);
        check("r0_dones", dn, 0);
        check("r0_read", RB_DATA, 0);

        // Invalid capture, then a normal frame
        drive(0, 5'h01, 5'd4, 0, 16'h4444);
        RA_ADDR = 5'd4;
        run(FRAME_LEN, dn, fst, rp, rc);
        check("inv_dones", dn, 0);
        check("inv_r4", RA_DATA, 0);
        drive(1, 5'h01, 5'd4, 0, 16'h4444);
        run(FRAME_LEN, dn, fst, rp, rc);
        check("val_dones", dn, 1);
        check("val_r4", RA_DATA, 16'h4444);

        // Bypass during COMMIT only
        drive(1, 5'h01, 5'd9, 0, 16'h5555);
        RA_ADDR = 5'd9;
        run(FRAME_LEN, dn, fst, rp, rc);
        check("byp_capture", rp, 0);
        check("byp_commit", rc, 16'h5555);
        check("byp_wbaddr", WB_ADDR, 9);

        // Reset arriving during COMMIT aborts the write
        drive(1, 5'h01, 5'd10, 0, 16'h6666);
        RA_ADDR = 5'd10;
        RB_ADDR = 5'd9;
        run(FRAME_LEN - 1, dn, fst, rp, rc);
        check("abort_pre_r10", RA_DATA, 16'h6666);
        RST = 1'b0;
        step();
        check("abort_done", WB_DONE, 0);
        check("abort_r10", RA_DATA, 0);
        check("abort_r9", RB_DATA, 0);
        check("abort_wbaddr", WB_ADDR, 0);
        check("abort_wbdata", WB_DATA, 0);
        RST = 1'b1;
        run(FIRST_FRAME_LEN, dn, fst, rp, rc);
        check("post_rst_cycle", fst, 13);
        check("post_rst_r10", RA_DATA, 16'h6666);
        run(FRAME_LEN, dn, fst, rp, rc);
        check("post_rst_steady", fst, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
